mem_wait_ctrl: RTL and testbench

MEM_WAIT_CTRL -- requirements
Module: mem_wait_ctrl

---
 rtl/mem_wait_pkg.sv | 21 ++
 rtl/mem_wait_array.sv | 85 ++++++++
 rtl/mem_wait_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_wait_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wait_pkg.sv
// Shared types and constants for the mem_wait_ctrl memory controller.
// Holds the FSM state encoding, read/write strobe values and the wait counter width.
package mem_wait_pkg;

    localparam int WAIT_CNT_W = 4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Word-index width; a single-word memory still needs a 1-bit index.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_wait_array.sv
// Word storage for mem_wait_ctrl: synchronous byte-enabled write, registered read.
// With MEM_WAIT_CTRL_PARITY_EN defined, keeps one even-parity bit per word and flags mismatches on read.
module mem_wait_array
    import mem_wait_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 65536,
    parameter int IDX_W  = idx_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [IDX_W-1:0]      i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_re,
    input  logic                  i_rzero,
    output logic [DATA_W-1:0]     o_rdata
`ifdef MEM_WAIT_CTRL_PARITY_EN
    ,
    output logic                  o_perr
`endif
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

`ifdef MEM_WAIT_CTRL_PARITY_EN
    logic              r_par [DEPTH];
    logic              r_perr;
    logic [DATA_W-1:0] w_merged;

    // Parity covers the whole merged word, so partial writes read-modify-write.
    always_comb begin
        w_merged = r_mem[i_addr];
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (i_be[b]) begin
                w_merged[b*8 +: 8] = i_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= w_merged;
            r_par[i_addr] <= ^w_merged;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rzero ? '0 : r_mem[i_addr];
        end
    end

`ifdef MEM_WAIT_CTRL_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= i_re & ~i_rzero & ((^r_mem[i_addr]) != r_par[i_addr]);
        end
    end

    assign o_perr = r_perr;
`endif

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_wait_ctrl.sv
// Wait-state memory controller: accepts a request in IDLE, stalls WAIT_CYCLES clocks, then performs it.
// Define MEM_WAIT_CTRL_PARITY_EN to add per-word parity storage and the perr output.
module mem_wait_ctrl
    import mem_wait_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 65536,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  readwrite,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     datain,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     dataout,
    output logic                  MFC,
    output logic                  busy,
    output logic                  addr_err
`ifdef MEM_WAIT_CTRL_PARITY_EN
    ,
    output logic                  perr
`endif
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = idx_width(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WAIT_CNT_W-1:0]  r_cnt;
    logic [WAIT_CNT_W-1:0]  w_cnt_nxt;
    logic                   w_accept;
    logic                   w_access;

    logic [ADDR_W-1:0]      r_addr;
    logic                   r_rw;
    logic [DATA_W-1:0]      r_din;
    logic [BE_W-1:0]        r_be;
    logic                   r_mfc;
    logic                   r_addr_err;

    logic                   w_oor;
    logic                   w_we;
    logic                   w_re;
    logic [IDX_W-1:0]       w_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (enable) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = ACCESS;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ACCESS;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ACCESS: begin
                w_access    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_rw   <= RW_READ;
            r_din  <= '0;
            r_be   <= '0;
        end else if (w_accept) begin
            r_addr <= address;
            r_rw   <= readwrite;
            r_din  <= datain;
            r_be   <= be;
        end
    end

    // MFC, addr_err and the read data all register on the edge that leaves ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mfc      <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_mfc      <= w_access;
            r_addr_err <= w_access & w_oor;
        end
    end

    assign w_oor = ({1'b0, r_addr} >= DEPTH_L);
    assign w_we  = w_access & (r_rw == RW_WRITE) & ~w_oor;
    assign w_re  = w_access & (r_rw == RW_READ);
    assign w_idx = r_addr[IDX_W-1:0];

    mem_wait_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_be    (r_be),
        .i_addr  (w_idx),
        .i_wdata (r_din),
        .i_re    (w_re),
        .i_rzero (w_oor),
        .o_rdata (dataout)
`ifdef MEM_WAIT_CTRL_PARITY_EN
        ,
        .o_perr  (perr)
`endif
    );

    assign MFC      = r_mfc;
    assign busy     = (r_state != IDLE);
    assign addr_err = r_addr_err;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Self-checking bench for mem_wait_ctrl: directed scenarios plus randomized traffic vs. a reference model.
// Two instances: WAIT_CYCLES=2 (main) and WAIT_CYCLES=0 (single-cycle latency), both DEPTH=256.
module tb_mem_wait_ctrl;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int DEP = 256;
    localparam int WA  = 2;
    localparam int WB  = 0;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_a  = 1'b0;
    logic          en_b  = 1'b0;
    logic          rw    = 1'b1;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] din   = '0;
    logic [1:0]    be    = '0;

    logic [DW-1:0] dout_a, dout_b;
    logic          mfc_a, mfc_b, busy_a, busy_b, aerr_a, aerr_b;
`ifdef MEM_WAIT_CTRL_PARITY_EN
    logic          perr_a, perr_b;
`endif

    int            total = 0;
    int            bad   = 0;
    int unsigned   cyc   = 0;

    logic [DW-1:0] ref_a [int unsigned];
    logic [DW-1:0] ref_b [int unsigned];
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;
    bit            exp_perr = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_wait_ctrl #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .DEPTH       (DEP),
        .WAIT_CYCLES (WA)
    ) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (en_a),
        .readwrite (rw),
        .address   (addr),
        .datain    (din),
        .be        (be),
        .dataout   (dout_a),
        .MFC       (mfc_a),
        .busy      (busy_a),
        .addr_err  (aerr_a)
`ifdef MEM_WAIT_CTRL_PARITY_EN
        ,
        .perr      (perr_a)
`endif
    );

    mem_wait_ctrl #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .DEPTH       (DEP),
        .WAIT_CYCLES (WB)
    ) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (en_b),
        .readwrite (rw),
        .address   (addr),
        .datain    (din),
        .be        (be),
        .dataout   (dout_b),
        .MFC       (mfc_b),
        .busy      (busy_b),
        .addr_err  (aerr_b)
`ifdef MEM_WAIT_CTRL_PARITY_EN
        ,
        .perr      (perr_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete request on instance sel (0 = u_a, 1 = u_b); expectations come from the model.
    task automatic do_req(input bit sel, input logic r, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [1:0] b);
        int unsigned   acc;
        int unsigned   lat;
        int unsigned   w;
        int            n;
        logic [DW-1:0] old_w;
        logic [DW-1:0] new_w;
        logic [DW-1:0] expd;
        w = sel ? WB : WA;
        @(negedge clk);
        rw = r; addr = a; din = d; be = b;
        if (sel) en_b = 1'b1; else en_a = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        en_a = 1'b0; en_b = 1'b0;
        chk("busy_after_accept", 32'(sel ? busy_b : busy_a), 32'd1);
        n = 0;
        while ((sel ? mfc_b : mfc_a) !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - acc;
        chk("latency", lat, w + 1);
        chk("busy_at_mfc", 32'(sel ? busy_b : busy_a), 32'd0);
        chk("addr_err_at_mfc", 32'(sel ? aerr_b : aerr_a), 32'(a >= AW'(DEP)));
        if (r) begin
            if (a >= AW'(DEP)) expd = '0;
            else expd = sel ? ref_b[32'(a)] : ref_a[32'(a)];
            chk("rdata", 32'(sel ? dout_b : dout_a), 32'(expd));
            if (sel) last_b = expd; else last_a = expd;
        end else begin
            chk("dout_hold_on_write", 32'(sel ? dout_b : dout_a), 32'(sel ? last_b : last_a));
            if (a < AW'(DEP)) begin
                old_w = sel ? ref_b[32'(a)] : ref_a[32'(a)];
                new_w = old_w;
                if (b[0]) new_w[7:0]  = d[7:0];
                if (b[1]) new_w[15:8] = d[15:8];
                if (sel) ref_b[32'(a)] = new_w; else ref_a[32'(a)] = new_w;
            end
        end
`ifdef MEM_WAIT_CTRL_PARITY_EN
        chk("perr_at_mfc", 32'(sel ? perr_b : perr_a), 32'(r && exp_perr));
`endif
        @(negedge clk);
        chk("mfc_one_cycle", 32'(sel ? mfc_b : mfc_a), 32'd0);
        chk("addr_err_low", 32'(sel ? aerr_b : aerr_a), 32'd0);
    endtask

    initial begin
        int            n_acc;
        int            n_win;
        int            pulses;
        int            extra;
        int unsigned   t1;
        int unsigned   t2;
        int            n;
        logic [AW-1:0] pool [8];
        logic [AW-1:0] ra;
        bit            rs;

        // Reset values
        #2;
        chk("rst_dout", 32'(dout_a), 32'd0);
        chk("rst_mfc", 32'(mfc_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_addr_err", 32'(aerr_a), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read with default latency
        do_req(0, 1'b0, 16'h0010, 16'hABCD, 2'b11);
        do_req(0, 1'b1, 16'h0010, 16'h0000, 2'b00);

        // Byte enables
        do_req(0, 1'b0, 16'h0020, 16'h1234, 2'b11);
        do_req(0, 1'b0, 16'h0020, 16'hFF56, 2'b01);
        do_req(0, 1'b1, 16'h0020, 16'h0000, 2'b00);
        chk("byte_merge", 32'(dout_a), 32'h1256);

        // Zero byte-enable write changes nothing
        do_req(0, 1'b0, 16'h0050, 16'h7777, 2'b11);
        do_req(0, 1'b0, 16'h0050, 16'h0000, 2'b00);
        do_req(0, 1'b1, 16'h0050, 16'h0000, 2'b00);

        // Out-of-range: writes discarded (no aliasing onto low addresses), reads give zero
        do_req(0, 1'b0, 16'h0000, 16'h2468, 2'b11);
        do_req(0, 1'b0, 16'h0100, 16'hDEAD, 2'b11);
        do_req(0, 1'b1, 16'h0100, 16'h0000, 2'b00);
        do_req(0, 1'b1, 16'h0000, 16'h0000, 2'b00);

        // Zero wait states
        do_req(1, 1'b0, 16'h0010, 16'h9999, 2'b11);
        do_req(1, 1'b1, 16'h0010, 16'h0000, 2'b00);
        do_req(1, 1'b1, 16'h01FF, 16'h0000, 2'b00);

        // Busy hold-off: enable held for 10 clocks; each accept occupies WA+2 clocks
        n_acc = 0; n_win = 0;
        for (int t = 0; t < 10; t += WA + 2) begin
            n_acc++;
            if (t + WA + 1 <= 9) n_win++;
        end
        @(negedge clk);
        rw = 1'b1; addr = 16'h0010; be = 2'b00; en_a = 1'b1;
        pulses = 0; t1 = 0; t2 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mfc_a === 1'b1) begin
                pulses++;
                if (pulses == 1) t1 = cyc;
                if (pulses == 2) t2 = cyc;
            end
        end
        en_a = 1'b0;
        chk("holdoff_pulses", 32'(pulses), 32'(n_win));
        chk("holdoff_spacing", t2 - t1, WA + 2);
        extra = 0; n = 0;
        while ((busy_a === 1'b1 || mfc_a === 1'b1) && n < 40) begin
            if (mfc_a === 1'b1) extra++;
            @(negedge clk);
            n++;
        end
        chk("holdoff_drain", 32'(extra), 32'(n_acc - n_win));
        last_a = ref_a[32'h10];
        chk("holdoff_rdata", 32'(dout_a), 32'(last_a));

        // Reset in the middle of a write
        do_req(0, 1'b0, 16'h0030, 16'h1111, 2'b11);
        do_req(0, 1'b1, 16'h0030, 16'h0000, 2'b00);
        @(negedge clk);
        rw = 1'b0; addr = 16'h0030; din = 16'h5555; be = 2'b11; en_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en_a = 1'b0;
        chk("busy_in_wait", 32'(busy_a), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_dout", 32'(dout_a), 32'd0);
        chk("arst_mfc", 32'(mfc_a), 32'd0);
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_addr_err", 32'(aerr_a), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("mfc_during_reset", 32'(mfc_a), 32'd0);
        end
        rst_n = 1'b1;
        last_a = '0; last_b = '0;
        repeat (4) begin
            @(negedge clk);
            chk("no_mfc_after_abort", 32'(mfc_a), 32'd0);
        end
        do_req(0, 1'b1, 16'h0030, 16'h0000, 2'b00);

        // Randomized traffic over fully-initialised words plus out-of-range addresses
        for (int i = 0; i < 8; i++) begin
            pool[i] = AW'(16'h0060 + i);
            do_req(0, 1'b0, pool[i], DW'($urandom), 2'b11);
            do_req(1, 1'b0, pool[i], DW'($urandom), 2'b11);
        end
        for (int i = 0; i < 40; i++) begin
            rs = ($urandom_range(3) == 0);
            if ($urandom_range(7) == 0) ra = AW'(16'h0100 + $urandom_range(16'hFEFF));
            else ra = pool[$urandom_range(7)];
            do_req(rs, 1'($urandom_range(1)), ra, DW'($urandom), 2'($urandom_range(3)));
        end

`ifdef MEM_WAIT_CTRL_PARITY_EN
        // Corrupt one stored bit behind the parity bit's back
        do_req(0, 1'b0, 16'h0040, 16'h0F0F, 2'b11);
        u_a.u_array.r_mem[8'h40][3] = ~u_a.u_array.r_mem[8'h40][3];
        ref_a[32'h40] = ref_a[32'h40] ^ 16'h0008;
        exp_perr = 1'b1;
        do_req(0, 1'b1, 16'h0040, 16'h0000, 2'b00);
        exp_perr = 1'b0;
        do_req(0, 1'b0, 16'h0040, 16'h0F0F, 2'b11);
        do_req(0, 1'b1, 16'h0040, 16'h0000, 2'b00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
